axis_spm_dac_spi_tx: RTL and testbench

- Consumes the four SPM control output streams (X, Y, Z, Bias), each Q31 and always valid.
- Latches one sample set per frame and converts each sample to a rounded, saturated 20-bit two's-complement DAC code.
- Shifts the four 24-bit DAC write words out simultaneously on four parallel SDI lines with shared SCLK and SYNC_N.
- Sits between the SPM control block and four AD5791-class 20-bit DACs.

---
 rtl/spm_dac_pkg.sv | 29 ++
 rtl/q31_to_dac_code.sv | 45 ++++
 rtl/axis_spm_dac_spi_tx.sv | 229 ++++++++++++++++++++++
 tb/tb_axis_spm_dac_spi_tx.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spm_dac_pkg.sv
// -----------------------------------------------------------------------------
// spm_dac_pkg
// Shared types and constants for the SPM four-channel DAC SPI transmitter.
//   state_e        : transmitter frame state
//   DAC_WORD_W     : width of one DAC write word (command nibble + 20-bit code)
//   CMD_WRITE_DAC  : AD5791 "write DAC register" command nibble
//   CH_X..CH_U     : channel index of each stream on the parallel SDI bus
// -----------------------------------------------------------------------------
package spm_dac_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    SETUP = 3'd2,
    SHIFT = 3'd3,
    HOLD  = 3'd4,
    GAP   = 3'd5
  } state_e;

  localparam int         DAC_WORD_W    = 24;
  localparam logic [3:0] CMD_WRITE_DAC = 4'b0001;

  localparam int NUM_CH = 4;
  localparam int CH_X   = 0;
  localparam int CH_Y   = 1;
  localparam int CH_Z   = 2;
  localparam int CH_U   = 3;

endpackage

// File: rtl/q31_to_dac_code.sv
// -----------------------------------------------------------------------------
// q31_to_dac_code
// Combinational round-half-up and positive saturation of a signed fixed-point
// sample down to a DAC_BITS two's-complement code.
//   d_i    : signed input sample (Q31 for DATA_W = 32)
//   code_o : rounded, saturated DAC code
// The sum is formed one bit wider than the input so the rounding increment
// cannot wrap. Only the positive end can overflow: the most negative input
// plus the rounding constant still lies inside the code range.
// -----------------------------------------------------------------------------
module q31_to_dac_code #(
  parameter int DATA_W   = 32,
  parameter int DAC_BITS = 20
) (
  input  logic [DATA_W-1:0]   d_i,
  output logic [DAC_BITS-1:0] code_o
);

  localparam logic [DATA_W:0] ROUND_ADD =
    {{DATA_W{1'b0}}, 1'b1} << (DATA_W - 1 - DAC_BITS);
  localparam logic [DAC_BITS-1:0] CODE_MAX = {1'b0, {(DAC_BITS-1){1'b1}}};

  logic [DATA_W:0] sum_s;
  logic            overflow_s;
  logic            unused_frac_s;

  assign sum_s = {d_i[DATA_W-1], d_i} + ROUND_ADD;

  // Non-negative sum with bit DATA_W-1 set no longer fits the code range.
  assign overflow_s = ~sum_s[DATA_W] & sum_s[DATA_W-1];

  // Fraction bits below the code only matter through the rounding carry.
  assign unused_frac_s = ^sum_s[DATA_W-DAC_BITS-1:0];

  // Select saturated maximum or the arithmetic-shifted code.
  always_comb begin
    code_o = sum_s[DATA_W-1 -: DAC_BITS];
    if (overflow_s) begin
      code_o = CODE_MAX;
    end else begin
      code_o = sum_s[DATA_W-1 -: DAC_BITS];
    end
  end

endmodule

// File: rtl/axis_spm_dac_spi_tx.sv
// -----------------------------------------------------------------------------
// axis_spm_dac_spi_tx
// Latches one X/Y/Z/Bias sample set per frame, converts each Q31 sample to a
// 20-bit DAC code and shifts four {CMD, code} words out in parallel, MSB first,
// on a shared SCLK / SYNC_N to four AD5791-class DACs.
//
// Ports
//   a_clk, a_rst                     : clock, asynchronous active-high reset
//   S_AXIS_{X,Y,Z,U}_tdata/_tvalid   : Q31 sample streams (always valid)
//   S_AXIS_tready                    : one-cycle pulse while samples are taken
//   spi_sclk                         : shared serial clock, idles low
//   spi_sync_n                       : shared frame select, active low
//   spi_sdi[3:0]                     : serial data, bit0=X bit1=Y bit2=Z bit3=U
//   ldac_n                           : DAC load strobe
//   frame_cnt                        : completed frames, wraps at 2^32
//   busy                             : high whenever not in IDLE
//
// Build option
//   SPM_DAC_TX_LDAC_EN : when defined, ldac_n idles high and pulses low for
//                        SCLK_DIV clocks from the first GAP cycle. Otherwise
//                        ldac_n is tied low and the DACs update on SYNC_N rise.
// -----------------------------------------------------------------------------
module axis_spm_dac_spi_tx
  import spm_dac_pkg::*;
#(
  parameter int         SAXIS_TDATA_WIDTH = 32,
  parameter int         DAC_BITS          = 20,
  parameter logic [3:0] CMD               = CMD_WRITE_DAC,
  parameter int         SCLK_DIV          = 2,
  parameter int         GAP_CYC           = 8
) (
  input  logic                         a_clk,
  input  logic                         a_rst,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_X_tdata,
  input  logic                         S_AXIS_X_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_Y_tdata,
  input  logic                         S_AXIS_Y_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_Z_tdata,
  input  logic                         S_AXIS_Z_tvalid,
  input  logic [SAXIS_TDATA_WIDTH-1:0] S_AXIS_U_tdata,
  input  logic                         S_AXIS_U_tvalid,
  output logic                         S_AXIS_tready,
  output logic                         spi_sclk,
  output logic                         spi_sync_n,
  output logic [3:0]                   spi_sdi,
  output logic                         ldac_n,
  output logic [31:0]                  frame_cnt,
  output logic                         busy
);

  localparam int WORD_W = 4 + DAC_BITS;
  localparam int BIT_W  = $clog2(WORD_W);
  localparam int CNT_W  = 16;

  localparam logic [CNT_W-1:0] DIV_LAST = CNT_W'(SCLK_DIV - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYC - 1);
  localparam logic [BIT_W-1:0] BIT_TOP  = BIT_W'(WORD_W - 1);
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);

  logic [NUM_CH-1:0][SAXIS_TDATA_WIDTH-1:0] tdata_s;
  logic [NUM_CH-1:0][DAC_BITS-1:0]          codes_s;
  logic [NUM_CH-1:0][WORD_W-1:0]            words_d;
  logic                                     all_valid_s;

  state_e                          state_q;
  logic [CNT_W-1:0]                cnt_q;
  logic [BIT_W-1:0]                bit_cnt_q;
  // Bits still to send; the bit on the wire lives in sdi_q.
  logic [NUM_CH-1:0][WORD_W-2:0]   sr_q;
  logic [NUM_CH-1:0]               sdi_q;
  logic                            sclk_q;
  logic                            sync_n_q;
  logic                            tready_q;
  logic                            busy_q;
  logic [31:0]                     frame_cnt_q;

  assign tdata_s[CH_X] = S_AXIS_X_tdata;
  assign tdata_s[CH_Y] = S_AXIS_Y_tdata;
  assign tdata_s[CH_Z] = S_AXIS_Z_tdata;
  assign tdata_s[CH_U] = S_AXIS_U_tdata;

  assign all_valid_s = S_AXIS_X_tvalid & S_AXIS_Y_tvalid &
                       S_AXIS_Z_tvalid & S_AXIS_U_tvalid;

  for (genvar ch = 0; ch < NUM_CH; ch++) begin : g_conv
    q31_to_dac_code #(
      .DATA_W   (SAXIS_TDATA_WIDTH),
      .DAC_BITS (DAC_BITS)
    ) u_conv (
      .d_i    (tdata_s[ch]),
      .code_o (codes_s[ch])
    );
    assign words_d[ch] = {CMD, codes_s[ch]};
  end

  // Frame sequencer: IDLE -> LOAD -> SETUP -> SHIFT -> HOLD -> GAP -> IDLE.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      bit_cnt_q   <= '0;
      sr_q        <= '0;
      sdi_q       <= '0;
      sclk_q      <= 1'b0;
      sync_n_q    <= 1'b1;
      tready_q    <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (all_valid_s) begin
            state_q  <= LOAD;
            tready_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        LOAD: begin
          // Samples are captured at the end of the tready cycle.
          tready_q <= 1'b0;
          sync_n_q <= 1'b0;
          sclk_q   <= 1'b0;
          cnt_q    <= 16'd0;
          state_q  <= SETUP;
          for (int ch = 0; ch < NUM_CH; ch++) begin
            sdi_q[ch] <= words_d[ch][WORD_W-1];
            sr_q[ch]  <= words_d[ch][WORD_W-2:0];
          end
        end
        SETUP: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q     <= 16'd0;
            sclk_q    <= 1'b1;
            bit_cnt_q <= BIT_TOP;
            state_q   <= SHIFT;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        SHIFT: begin
          if (cnt_q != DIV_LAST) begin
            cnt_q <= cnt_q + 16'd1;
          end else begin
            cnt_q <= 16'd0;
            if (sclk_q) begin
              sclk_q <= 1'b0;
            end else if (bit_cnt_q == '0) begin
              state_q <= HOLD;
            end else begin
              // Data changes on the rising edge, a half period before sampling.
              bit_cnt_q <= bit_cnt_q - BIT_ONE;
              sclk_q    <= 1'b1;
              for (int ch = 0; ch < NUM_CH; ch++) begin
                sdi_q[ch] <= sr_q[ch][WORD_W-2];
                sr_q[ch]  <= {sr_q[ch][WORD_W-3:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          if (cnt_q == DIV_LAST) begin
            cnt_q       <= 16'd0;
            sync_n_q    <= 1'b1;
            sdi_q       <= '0;
            frame_cnt_q <= frame_cnt_q + 32'd1;
            state_q     <= GAP;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= 16'd0;
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: begin
          state_q  <= IDLE;
          cnt_q    <= '0;
          sdi_q    <= '0;
          sclk_q   <= 1'b0;
          sync_n_q <= 1'b1;
          tready_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign S_AXIS_tready = tready_q;
  assign spi_sclk      = sclk_q;
  assign spi_sync_n    = sync_n_q;
  assign spi_sdi       = sdi_q;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = busy_q;

`ifdef SPM_DAC_TX_LDAC_EN
  logic             ldac_n_q;
  logic [CNT_W-1:0] ldac_cnt_q;

  // LDAC pulse: low for SCLK_DIV clocks starting with the first GAP cycle;
  // held at its idle-high level through reset.
  always_ff @(posedge a_clk or posedge a_rst) begin
    if (a_rst) begin
      ldac_n_q   <= 1'b1;
      ldac_cnt_q <= '0;
    end else if ((state_q == HOLD) && (cnt_q == DIV_LAST)) begin
      ldac_n_q   <= 1'b0;
      ldac_cnt_q <= 16'd0;
    end else if (!ldac_n_q) begin
      if (ldac_cnt_q == DIV_LAST) begin
        ldac_n_q <= 1'b1;
      end else begin
        ldac_cnt_q <= ldac_cnt_q + 16'd1;
      end
    end else begin
      ldac_n_q <= 1'b1;
    end
  end

  assign ldac_n = ldac_n_q;
`else
  assign ldac_n = 1'b0;
`endif

endmodule

// File: tb/tb_axis_spm_dac_spi_tx.sv
module tb_axis_spm_dac_spi_tx;

  logic        a_clk = 1'b0;
  logic        a_rst = 1'b1;
  logic [31:0] tx = 32'd0, ty = 32'd0, tz = 32'd0, tu = 32'd0;
  logic        vx = 1'b0, vy = 1'b0, vz = 1'b0, vu = 1'b0;
  logic        S_AXIS_tready, spi_sclk, spi_sync_n, ldac_n, busy;
  logic [3:0]  spi_sdi;
  logic [31:0] frame_cnt;

`ifdef SPM_DAC_TX_LDAC_EN
  localparam logic LDAC_IDLE = 1'b1;
`else
  localparam logic LDAC_IDLE = 1'b0;
`endif

  axis_spm_dac_spi_tx dut (
    .a_clk           (a_clk),
    .a_rst           (a_rst),
    .S_AXIS_X_tdata  (tx),
    .S_AXIS_X_tvalid (vx),
    .S_AXIS_Y_tdata  (ty),
    .S_AXIS_Y_tvalid (vy),
    .S_AXIS_Z_tdata  (tz),
    .S_AXIS_Z_tvalid (vz),
    .S_AXIS_U_tdata  (tu),
    .S_AXIS_U_tvalid (vu),
    .S_AXIS_tready   (S_AXIS_tready),
    .spi_sclk        (spi_sclk),
    .spi_sync_n      (spi_sync_n),
    .spi_sdi         (spi_sdi),
    .ldac_n          (ldac_n),
    .frame_cnt       (frame_cnt),
    .busy            (busy)
  );

  always #5 a_clk = ~a_clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Bus monitor state (written only by the monitor process).
  int               cyc = 0, fall_cnt = 0, frames_seen = 0, load_cnt = 0;
  int               period_cnt = 0, period_bad = 0, last_load_cyc = 0;
  int               gap_done = 0, gap_bad = 0, gap_len = 0, last_gap = 0;
  int               last_falls = 0, ldac_bad = 0, ldac_run = 0, last_ldac_run = 0, ldac_pulses = 0;
  logic [3:0][23:0] cap = '0, last_words = '0;
  bit               prev_sclk = 1'b0, prev_sync = 1'b1, have_load = 1'b0, gap_on = 1'b0;

  always @(negedge a_clk) begin
    cyc++;
`ifndef SPM_DAC_TX_LDAC_EN
    if (ldac_n !== 1'b0) ldac_bad++;
`endif
    if (a_rst) begin
      fall_cnt = 0; cap = '0; prev_sclk = 1'b0; prev_sync = 1'b1;
      have_load = 1'b0; gap_on = 1'b0; ldac_run = 0;
    end else begin
      if (prev_sclk && !spi_sclk && !spi_sync_n) begin
        for (int ch = 0; ch < 4; ch++) cap[ch] = {cap[ch][22:0], spi_sdi[ch]};
        fall_cnt++;
      end
      if (!prev_sync && spi_sync_n) begin
        last_words = cap; last_falls = fall_cnt; frames_seen++;
        cap = '0; fall_cnt = 0; gap_on = 1'b1; gap_len = 0;
`ifdef SPM_DAC_TX_LDAC_EN
        if (ldac_n !== 1'b0) ldac_bad++;
`endif
      end
      if (gap_on) begin
        if (spi_sync_n && busy) gap_len++;
        else begin
          gap_on = 1'b0; last_gap = gap_len; gap_done++;
          if (gap_len != 8) gap_bad++;
        end
      end
      if (S_AXIS_tready) begin
        load_cnt++;
        if (have_load) begin
          period_cnt++;
          if (cyc - last_load_cyc != 110) period_bad++;
        end
        last_load_cyc = cyc; have_load = 1'b1;
      end
`ifdef SPM_DAC_TX_LDAC_EN
      if (ldac_n === 1'b0) ldac_run++;
      else if (ldac_run != 0) begin
        last_ldac_run = ldac_run; ldac_run = 0; ldac_pulses++;
      end
`endif
      prev_sclk = spi_sclk; prev_sync = spi_sync_n;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic set_data(input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] z, input logic [31:0] u);
    tx = x; ty = y; tz = z; tu = u;
  endtask

  task automatic set_valid(input logic v);
    vx = v; vy = v; vz = v; vu = v;
  endtask

  task automatic do_reset();
    @(negedge a_clk); #2 a_rst = 1'b1;
    repeat (2) @(negedge a_clk);
    #2 a_rst = 1'b0;
  endtask

  task automatic wait_load(output bit ok);
    int target = load_cnt + 1;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge a_clk); #1;
      if (load_cnt >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_frames(input int n, output bit ok);
    int target = frames_seen + n;
    ok = 1'b0;
    for (int i = 0; i < n * 150 + 50; i++) begin
      @(negedge a_clk); #1;
      if (frames_seen >= target) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_falls(input int k, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge a_clk); #1;
      if (fall_cnt >= k) begin ok = 1'b1; break; end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge a_clk); #1;
      if (busy === 1'b0) begin ok = 1'b1; break; end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge a_clk); #2 a_rst = 1'b1;
    @(negedge a_clk); #1;
    n_checks++; if (spi_sclk !== 1'b0) $display("FAIL reset_sclk got %b exp 0", spi_sclk); else n_pass++;
    n_checks++; if (spi_sync_n !== 1'b1) $display("FAIL reset_sync_n got %b exp 1", spi_sync_n); else n_pass++;
    n_checks++; if (spi_sdi !== 4'h0) $display("FAIL reset_sdi got %h exp 0", spi_sdi); else n_pass++;
    n_checks++; if (S_AXIS_tready !== 1'b0) $display("FAIL reset_tready got %b exp 0", S_AXIS_tready); else n_pass++;
    n_checks++; if (ldac_n !== LDAC_IDLE) $display("FAIL reset_ldac_n got %b exp %b", ldac_n, LDAC_IDLE); else n_pass++;
    n_checks++; if (frame_cnt !== 32'd0) $display("FAIL reset_frame_cnt got %0d exp 0", frame_cnt); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy got %b exp 0", busy); else n_pass++;
    @(negedge a_clk); #2 a_rst = 1'b0;
  endtask

  task automatic test_words();
    bit ok;
    logic [3:0][23:0] exp_w;
    exp_w[0] = 24'h100000; exp_w[1] = 24'h17FFFF; exp_w[2] = 24'h180000; exp_w[3] = 24'h100001;
    set_data(32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000800);
    set_valid(1'b1);
    wait_load(ok);
    n_checks++; if (!ok) $display("FAIL words_load got timeout exp tready pulse"); else n_pass++;
    set_valid(1'b0);
    wait_frames(1, ok);
    n_checks++; if (!ok) $display("FAIL words_frame got timeout exp frame end"); else n_pass++;
    for (int ch = 0; ch < 4; ch++) begin
      n_checks++;
      if (last_words[ch] !== exp_w[ch]) $display("FAIL words_ch%0d got %h exp %h", ch, last_words[ch], exp_w[ch]);
      else n_pass++;
    end
    n_checks++; if (last_falls != 24) $display("FAIL words_falls got %0d exp 24", last_falls); else n_pass++;
    n_checks++; if (frame_cnt !== 32'd1) $display("FAIL words_frame_cnt got %0d exp 1", frame_cnt); else n_pass++;
    wait_idle(ok);
    n_checks++; if (!ok) $display("FAIL words_idle got timeout exp busy low"); else n_pass++;
  endtask

  task automatic test_rounding();
    bit ok;
    logic [3:0][23:0] exp_w;
    exp_w[0] = 24'h100000; exp_w[1] = 24'h100000; exp_w[2] = 24'h1FFFFF; exp_w[3] = 24'h17FFFF;
    set_data(32'h000007FF, 32'hFFFFF800, 32'hFFFFF7FF, 32'h7FFFF800);
    set_valid(1'b1);
    wait_load(ok);
    set_valid(1'b0);
    wait_frames(1, ok);
    n_checks++; if (!ok) $display("FAIL round_frame got timeout exp frame end"); else n_pass++;
    for (int ch = 0; ch < 4; ch++) begin
      n_checks++;
      if (last_words[ch] !== exp_w[ch]) $display("FAIL round_ch%0d got %h exp %h", ch, last_words[ch], exp_w[ch]);
      else n_pass++;
    end
    n_checks++; if (frame_cnt !== 32'd2) $display("FAIL round_frame_cnt got %0d exp 2", frame_cnt); else n_pass++;
    wait_idle(ok);
  endtask

  task automatic test_reset_mid();
    bit ok;
    do_reset();
    set_data(32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'h00000800);
    set_valid(1'b1);
    wait_falls(11, ok);
    n_checks++; if (!ok) $display("FAIL rstmid_falls got timeout exp 11 falls"); else n_pass++;
    n_checks++; if (spi_sync_n !== 1'b0) $display("FAIL rstmid_pre_sync got %b exp 0", spi_sync_n); else n_pass++;
    repeat (2) @(negedge a_clk);
    #2 a_rst = 1'b1;
    #1;
    n_checks++; if (spi_sync_n !== 1'b1) $display("FAIL rstmid_sync got %b exp 1", spi_sync_n); else n_pass++;
    n_checks++; if (spi_sclk !== 1'b0) $display("FAIL rstmid_sclk got %b exp 0", spi_sclk); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy got %b exp 0", busy); else n_pass++;
    n_checks++; if (frame_cnt !== 32'd0) $display("FAIL rstmid_frame_cnt got %0d exp 0", frame_cnt); else n_pass++;
    @(negedge a_clk); @(negedge a_clk); #2 a_rst = 1'b0;
    wait_frames(1, ok);
    set_valid(1'b0);
    n_checks++; if (!ok) $display("FAIL rstmid_next got timeout exp frame end"); else n_pass++;
    n_checks++; if (last_words[1] !== 24'h17FFFF) $display("FAIL rstmid_word_y got %h exp 17ffff", last_words[1]); else n_pass++;
    n_checks++; if (last_words[3] !== 24'h100001) $display("FAIL rstmid_word_u got %h exp 100001", last_words[3]); else n_pass++;
    n_checks++; if (last_falls != 24) $display("FAIL rstmid_falls_after got %0d exp 24", last_falls); else n_pass++;
    n_checks++; if (frame_cnt !== 32'd1) $display("FAIL rstmid_cnt_after got %0d exp 1", frame_cnt); else n_pass++;
    wait_idle(ok);
  endtask

  task automatic test_continuous();
    bit ok;
    int pb, pc, gb, gd;
    do_reset();
    pb = period_bad; pc = period_cnt; gb = gap_bad; gd = gap_done;
    set_data(32'h01000000, 32'hFF000000, 32'h00000000, 32'h00000000);
    set_valid(1'b1);
    wait_frames(10, ok);
    n_checks++; if (!ok) $display("FAIL cont_frames got timeout exp 10 frames"); else n_pass++;
    n_checks++; if (frame_cnt !== 32'd10) $display("FAIL cont_frame_cnt got %0d exp 10", frame_cnt); else n_pass++;
    n_checks++; if (period_cnt - pc != 9) $display("FAIL cont_periods got %0d exp 9", period_cnt - pc); else n_pass++;
    n_checks++; if (period_bad - pb != 0) $display("FAIL cont_period_110 got %0d bad exp 0", period_bad - pb); else n_pass++;
    n_checks++; if (gap_done - gd != 9) $display("FAIL cont_gaps got %0d exp 9", gap_done - gd); else n_pass++;
    n_checks++; if (gap_bad - gb != 0) $display("FAIL cont_gap_len got %0d bad (last %0d) exp 0", gap_bad - gb, last_gap); else n_pass++;
    set_valid(1'b0);
    wait_idle(ok);
    wait_idle(ok);
  endtask

  task automatic test_inflight();
    bit ok;
    set_data(32'h12345678, 32'hEDCBA987, 32'h40000000, 32'hC0000000);
    set_valid(1'b1);
    wait_load(ok);
    repeat (20) @(negedge a_clk);
    set_data(32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h7FFFFFFF);
    set_valid(1'b0);
    wait_frames(1, ok);
    n_checks++; if (last_words[0] !== 24'h112345) $display("FAIL inflight_x got %h exp 112345", last_words[0]); else n_pass++;
    n_checks++; if (last_words[1] !== 24'h1EDCBB) $display("FAIL inflight_y got %h exp 1edcbb", last_words[1]); else n_pass++;
    n_checks++; if (last_words[2] !== 24'h140000) $display("FAIL inflight_z got %h exp 140000", last_words[2]); else n_pass++;
    n_checks++; if (last_words[3] !== 24'h1C0000) $display("FAIL inflight_u got %h exp 1c0000", last_words[3]); else n_pass++;
    wait_idle(ok);
  endtask

  task automatic test_valid_gating();
    bit ok;
    int l0;
    set_data(32'h12345678, 32'hEDCBA987, 32'h40000000, 32'hC0000000);
    vx = 1'b1; vy = 1'b0; vz = 1'b1; vu = 1'b1;
    l0 = load_cnt;
    repeat (300) @(negedge a_clk);
    #1;
    n_checks++; if (load_cnt != l0) $display("FAIL gate_noload got %0d loads exp 0", load_cnt - l0); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL gate_busy got %b exp 0", busy); else n_pass++;
    vy = 1'b1;
    wait_load(ok);
    n_checks++; if (!ok) $display("FAIL gate_load got timeout exp tready pulse"); else n_pass++;
    set_valid(1'b0);
    wait_frames(1, ok);
    n_checks++; if (last_words[1] !== 24'h1EDCBB) $display("FAIL gate_word_y got %h exp 1edcbb", last_words[1]); else n_pass++;
    wait_idle(ok);
  endtask

  task automatic test_ldac();
    n_checks++; if (ldac_bad != 0) $display("FAIL ldac_level got %0d bad samples exp 0", ldac_bad); else n_pass++;
`ifdef SPM_DAC_TX_LDAC_EN
    n_checks++; if (last_ldac_run != 2) $display("FAIL ldac_width got %0d exp 2", last_ldac_run); else n_pass++;
    n_checks++; if (ldac_pulses == 0) $display("FAIL ldac_pulses got 0 exp nonzero"); else n_pass++;
`endif
  endtask

  initial begin
    test_reset();
    test_words();
    test_rounding();
    test_reset_mid();
    test_continuous();
    test_inflight();
    test_valid_gating();
    test_ldac();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
